// File: rtl/unified_mem_arbiter_if.sv
// Bundles the fetch port, data port, memory port and stall outputs of the unified memory arbiter.
// The slave modport is the arbiter's view. The master modport is the pipeline and memory side.
interface unified_mem_arbiter_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic [DATA_W-1:0] if_rdata;
   logic              if_ready;
   logic              d_read;
   logic              d_write;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic [DATA_W-1:0] d_rdata;
   logic              d_ready;
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              stall_if;
   logic              stall_pipe;

   modport slave (
      input  if_req, if_addr, d_read, d_write, d_addr, d_wdata, mem_rdata,
      output if_rdata, if_ready, d_rdata, d_ready, mem_en, mem_we, mem_addr, mem_wdata,
      output stall_if, stall_pipe
   );

   modport master (
      output if_req, if_addr, d_read, d_write, d_addr, d_wdata, mem_rdata,
      input  if_rdata, if_ready, d_rdata, d_ready, mem_en, mem_we, mem_addr, mem_wdata,
      input  stall_if, stall_pipe
   );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Shares one fixed-latency single-port memory between instruction fetch and data access.
// Arbitration alternates when both sides compete. Each access runs strictly one at a time.
module unified_mem_arbiter #(
   parameter int unsigned MEM_LATENCY = 2,
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned DATA_W      = 32
) (
   input logic                  clk,
   input logic                  reset,
   unified_mem_arbiter_if.slave bus
);
   localparam int unsigned CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

   typedef enum logic [2:0] {StIdle, StServeI, StServeD, StDoneI, StDoneD} state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              last_d_q, last_d_d;
   logic              en_q, en_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
   logic              d_req;
   logic              if_rdy;
   logic              d_rdy;

   assign d_req = bus.d_read | bus.d_write;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      last_d_d   = last_d_q;
      en_d       = 1'b0;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      if_rdata_d = if_rdata_q;
      d_rdata_d  = d_rdata_q;
      unique case (state_q)
         StIdle: begin
            // Data wins a tie unless it was the last side served.
            if (d_req && (!bus.if_req || !last_d_q)) begin
               state_d  = StServeD;
               last_d_d = 1'b1;
               en_d     = 1'b1;
               we_d     = bus.d_write;
               addr_d   = bus.d_addr;
               wdata_d  = bus.d_wdata;
               cnt_d    = CNT_LOAD;
            end else if (bus.if_req) begin
               state_d  = StServeI;
               last_d_d = 1'b0;
               en_d     = 1'b1;
               we_d     = 1'b0;
               addr_d   = bus.if_addr;
               cnt_d    = CNT_LOAD;
            end
         end
         StServeI, StServeD: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else if (state_q == StServeI) begin
               if_rdata_d = bus.mem_rdata;
               state_d    = StDoneI;
            end else begin
               if (!we_q) begin
                  d_rdata_d = bus.mem_rdata;
               end
               state_d = StDoneD;
            end
         end
         StDoneI, StDoneD: state_d = StIdle;
         default:          state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         last_d_q   <= 1'b0;
         en_q       <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         if_rdata_q <= '0;
         d_rdata_q  <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         last_d_q   <= last_d_d;
         en_q       <= en_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         if_rdata_q <= if_rdata_d;
         d_rdata_q  <= d_rdata_d;
      end
   end

   assign if_rdy         = (state_q == StDoneI);
   assign d_rdy          = (state_q == StDoneD);
   assign bus.if_ready   = if_rdy;
   assign bus.d_ready    = d_rdy;
   assign bus.if_rdata   = if_rdata_q;
   assign bus.d_rdata    = d_rdata_q;
   assign bus.mem_en     = en_q;
   assign bus.mem_we     = we_q;
   assign bus.mem_addr   = addr_q;
   assign bus.mem_wdata  = wdata_q;
   assign bus.stall_if   = bus.if_req & ~if_rdy;
   assign bus.stall_pipe = d_req & ~d_rdy;
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: per-cycle vector table on a latency-2 instance,
// plus hand sequences for mid-access reset and back-to-back fetches on a latency-1 instance.
module tb_unified_mem_arbiter;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_chk = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   unified_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus_a ();
   unified_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus_b ();

   unified_mem_arbiter #(.MEM_LATENCY(2), .ADDR_W(32), .DATA_W(32)) dut_a (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_a)
   );

   unified_mem_arbiter #(.MEM_LATENCY(1), .ADDR_W(32), .DATA_W(32)) dut_b (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_b)
   );

   function automatic logic [31:0] mem_model(input logic [31:0] a);
      if (a == 32'h10) return 32'h0050_0093;
      return {~a[15:0], a[15:0]};
   endfunction

   // Memory drives real data only in the cycle where it is defined to be valid.
   logic [3:0] age_a = 4'd0;
   always @(posedge clk) begin
      if (bus_a.mem_en) age_a <= 4'd1;
      else if (age_a != 4'd0 && age_a < 4'd15) age_a <= age_a + 4'd1;
   end
   assign bus_a.mem_rdata = (age_a == 4'd1) ? mem_model(bus_a.mem_addr) : 32'hBAD0_BAD0;
   assign bus_b.mem_rdata = bus_b.mem_en ? mem_model(bus_b.mem_addr) : 32'hBAD0_BAD0;

   typedef struct {
      logic        ir, rd, wr;
      logic [31:0] ia, da, wd;
      logic [5:0]  fl;  // {mem_en, mem_we, if_ready, d_ready, stall_if, stall_pipe}
      logic [31:0] ma, mw, ird, drd;
   } vec_t;

   function automatic vec_t v(input logic ir, input logic rd, input logic wr,
                              input logic [31:0] ia, input logic [31:0] da,
                              input logic [31:0] wd, input logic [5:0] fl,
                              input logic [31:0] ma, input logic [31:0] mw,
                              input logic [31:0] ird, input logic [31:0] drd);
      vec_t r;
      r.ir = ir; r.rd = rd; r.wr = wr; r.ia = ia; r.da = da; r.wd = wd;
      r.fl = fl; r.ma = ma; r.mw = mw; r.ird = ird; r.drd = drd;
      return r;
   endfunction

   function automatic logic [133:0] act_a();
      return {bus_a.mem_en, bus_a.mem_we, bus_a.if_ready, bus_a.d_ready, bus_a.stall_if,
              bus_a.stall_pipe, bus_a.mem_addr, bus_a.mem_wdata, bus_a.if_rdata, bus_a.d_rdata};
   endfunction

   task automatic chk(input string name, input logic [133:0] act, input logic [133:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic apply(input vec_t x);
      bus_a.if_req  = x.ir;
      bus_a.d_read  = x.rd;
      bus_a.d_write = x.wr;
      bus_a.if_addr = x.ia;
      bus_a.d_addr  = x.da;
      bus_a.d_wdata = x.wd;
   endtask

   localparam logic [31:0] I1 = 32'h0050_0093;
   localparam logic [31:0] I2 = 32'hFFDF_0020;
   localparam logic [31:0] I3 = 32'hFFCF_0030;
   localparam logic [31:0] D1 = 32'hFF7F_0080;
   localparam logic [31:0] D2 = 32'hFF7B_0084;
   localparam logic [31:0] SW = 32'hDEAD_BEEF;
   localparam logic [31:0] SB = 32'h1234_5678;
   localparam logic [31:0] Z  = 32'h0;

   vec_t vecs[33];

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int en_n, en_at, rd_n, rd_at, idx;
      logic [31:0] rd_val;
      int en_c[4];
      int rd_c[4];

      // Fetch 0x10
      vecs[0]  = v(1'b1, 1'b0, 1'b0, 32'h10, Z, Z, 6'b000010, Z, Z, Z, Z);
      vecs[1]  = v(1'b1, 1'b0, 1'b0, 32'h10, Z, Z, 6'b100010, 32'h10, Z, Z, Z);
      vecs[2]  = v(1'b1, 1'b0, 1'b0, 32'h10, Z, Z, 6'b000010, 32'h10, Z, Z, Z);
      vecs[3]  = v(1'b1, 1'b0, 1'b0, 32'h10, Z, Z, 6'b001000, 32'h10, Z, I1, Z);
      vecs[4]  = v(1'b0, 1'b0, 1'b0, Z, Z, Z, 6'b000000, 32'h10, Z, I1, Z);
      // Contention: D, then I, then D
      vecs[5]  = v(1'b1, 1'b1, 1'b0, 32'h20, 32'h80, Z, 6'b000011, 32'h10, Z, I1, Z);
      vecs[6]  = v(1'b1, 1'b1, 1'b0, 32'h20, 32'h80, Z, 6'b100011, 32'h80, Z, I1, Z);
      vecs[7]  = v(1'b1, 1'b1, 1'b0, 32'h20, 32'h80, Z, 6'b000011, 32'h80, Z, I1, Z);
      vecs[8]  = v(1'b1, 1'b1, 1'b0, 32'h20, 32'h80, Z, 6'b000110, 32'h80, Z, I1, D1);
      vecs[9]  = v(1'b1, 1'b1, 1'b0, 32'h20, 32'h84, Z, 6'b000011, 32'h80, Z, I1, D1);
      vecs[10] = v(1'b1, 1'b1, 1'b0, 32'h20, 32'h84, Z, 6'b100011, 32'h20, Z, I1, D1);
      vecs[11] = v(1'b1, 1'b1, 1'b0, 32'h20, 32'h84, Z, 6'b000011, 32'h20, Z, I1, D1);
      vecs[12] = v(1'b1, 1'b1, 1'b0, 32'h20, 32'h84, Z, 6'b001001, 32'h20, Z, I2, D1);
      vecs[13] = v(1'b1, 1'b1, 1'b0, 32'h24, 32'h84, Z, 6'b000011, 32'h20, Z, I2, D1);
      vecs[14] = v(1'b1, 1'b1, 1'b0, 32'h24, 32'h84, Z, 6'b100011, 32'h84, Z, I2, D1);
      vecs[15] = v(1'b1, 1'b1, 1'b0, 32'h24, 32'h84, Z, 6'b000011, 32'h84, Z, I2, D1);
      vecs[16] = v(1'b1, 1'b1, 1'b0, 32'h24, 32'h84, Z, 6'b000110, 32'h84, Z, I2, D2);
      vecs[17] = v(1'b0, 1'b0, 1'b0, Z, Z, Z, 6'b000000, 32'h84, Z, I2, D2);
      // Store
      vecs[18] = v(1'b0, 1'b0, 1'b1, Z, 32'h40, SW, 6'b000001, 32'h84, Z, I2, D2);
      vecs[19] = v(1'b0, 1'b0, 1'b1, Z, 32'h40, SW, 6'b110001, 32'h40, SW, I2, D2);
      vecs[20] = v(1'b0, 1'b0, 1'b1, Z, 32'h40, SW, 6'b010001, 32'h40, SW, I2, D2);
      vecs[21] = v(1'b0, 1'b0, 1'b1, Z, 32'h40, SW, 6'b010100, 32'h40, SW, I2, D2);
      vecs[22] = v(1'b0, 1'b0, 1'b0, Z, Z, Z, 6'b010000, 32'h40, SW, I2, D2);
      // Read and write together behave as a store
      vecs[23] = v(1'b0, 1'b1, 1'b1, Z, 32'h44, SB, 6'b010001, 32'h40, SW, I2, D2);
      vecs[24] = v(1'b0, 1'b1, 1'b1, Z, 32'h44, SB, 6'b110001, 32'h44, SB, I2, D2);
      vecs[25] = v(1'b0, 1'b1, 1'b1, Z, 32'h44, SB, 6'b010001, 32'h44, SB, I2, D2);
      vecs[26] = v(1'b0, 1'b1, 1'b1, Z, 32'h44, SB, 6'b010100, 32'h44, SB, I2, D2);
      vecs[27] = v(1'b0, 1'b0, 1'b0, Z, Z, Z, 6'b010000, 32'h44, SB, I2, D2);
      // Fetch dropped during SERVE still completes once
      vecs[28] = v(1'b1, 1'b0, 1'b0, 32'h30, Z, Z, 6'b010010, 32'h44, SB, I2, D2);
      vecs[29] = v(1'b0, 1'b0, 1'b0, 32'h30, Z, Z, 6'b100000, 32'h30, SB, I2, D2);
      vecs[30] = v(1'b0, 1'b0, 1'b0, 32'h30, Z, Z, 6'b000000, 32'h30, SB, I2, D2);
      vecs[31] = v(1'b0, 1'b0, 1'b0, 32'h30, Z, Z, 6'b001000, 32'h30, SB, I3, D2);
      vecs[32] = v(1'b0, 1'b0, 1'b0, 32'h30, Z, Z, 6'b000000, 32'h30, SB, I3, D2);

      bus_a.if_req = 1'b1; bus_a.if_addr = 32'h10; bus_a.d_read = 1'b0;
      bus_a.d_write = 1'b0; bus_a.d_addr = Z; bus_a.d_wdata = Z;
      bus_b.if_req = 1'b0; bus_b.if_addr = Z; bus_b.d_read = 1'b0;
      bus_b.d_write = 1'b0; bus_b.d_addr = Z; bus_b.d_wdata = Z;

      // Reset state; stall_if follows if_req even during reset
      @(posedge clk); @(posedge clk); #1;
      @(negedge clk);
      chk("reset_state", act_a(), {6'b000010, Z, Z, Z, Z});

      @(posedge clk); #1;
      reset = 1'b0;
      for (int i = 0; i < 33; i++) begin
         if (i != 0) begin
            @(posedge clk); #1;
         end
         apply(vecs[i]);
         @(negedge clk);
         chk($sformatf("vec%0d", i), act_a(), {vecs[i].fl, vecs[i].ma, vecs[i].mw,
                                               vecs[i].ird, vecs[i].drd});
      end

      // Reset during the second SERVE_D cycle
      @(posedge clk); #1;
      bus_a.d_read = 1'b1; bus_a.d_addr = 32'h50;
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst_pre_en", {133'd0, bus_a.mem_en}, 134'd1);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("rst_mid_access", act_a(), {6'b000001, Z, Z, Z, Z});
      en_n = 0; en_at = -1; rd_n = 0; rd_at = -1; rd_val = Z;
      for (int k = 1; k <= 8; k++) begin
         @(posedge clk); #1;
         if (rd_n > 0) bus_a.d_read = 1'b0;
         @(negedge clk);
         if (bus_a.mem_en) begin en_n++; en_at = k; end
         if (bus_a.d_ready) begin rd_n++; rd_at = k; rd_val = bus_a.d_rdata; end
      end
      chk("rst_fresh_en_count", 134'(en_n), 134'd1);
      chk("rst_fresh_en_cycle", 134'(en_at), 134'd1);
      chk("rst_fresh_ready_count", 134'(rd_n), 134'd1);
      chk("rst_fresh_ready_cycle", 134'(rd_at), 134'd3);
      chk("rst_fresh_rdata", {102'd0, rd_val}, {102'd0, 32'hFFAF_0050});

      // Latency 1: back-to-back fetches to 0x0, 0x4, 0x8
      en_n = 0; rd_n = 0; idx = 0;
      for (int c = 0; c < 4; c++) begin en_c[c] = -1; rd_c[c] = -1; end
      @(posedge clk); #1;
      for (int c = 0; c < 12; c++) begin
         if (c != 0) begin
            @(posedge clk); #1;
         end
         bus_b.if_req  = (idx < 3);
         bus_b.if_addr = 32'(idx * 4);
         @(negedge clk);
         if (bus_b.mem_en && en_n < 4) begin
            chk($sformatf("l1_addr%0d", en_n), {102'd0, bus_b.mem_addr},
                {102'd0, 32'(idx * 4)});
            en_c[en_n] = c; en_n++;
         end
         if (bus_b.if_ready && rd_n < 4) begin
            chk($sformatf("l1_rdata%0d", rd_n), {102'd0, bus_b.if_rdata},
                {102'd0, mem_model(32'(idx * 4))});
            rd_c[rd_n] = c; rd_n++; idx++;
         end
      end
      chk("l1_en_count", 134'(en_n), 134'd3);
      chk("l1_ready_count", 134'(rd_n), 134'd3);
      for (int j = 0; j < 3; j++) begin
         chk($sformatf("l1_en_cycle%0d", j), 134'(en_c[j]), 134'(1 + 3 * j));
         chk($sformatf("l1_ready_cycle%0d", j), 134'(rd_c[j]), 134'(2 + 3 * j));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
